sram_slot_scheduler: RTL

SRAM_SLOT_SCHEDULER -- requirements
Module: sram_slot_scheduler

---
 rtl/sram_slot_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sram_slot_scheduler.sv
// sram_slot_scheduler: gives the delay effect and then the loop effect one
// bounded SRAM access window per audio frame. A one-cycle turnaround gap
// separates the two windows. The SRAM address, write enable and DQ driver
// follow whichever requester owns the current slot.
module sram_slot_scheduler #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_AUD_BCLK,
    input  logic        i_rst_n,
    input  logic        i_frame_start,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_done,
    input  logic [19:0] i_addr0,
    input  logic [19:0] i_addr1,
    input  logic [15:0] i_wdata0,
    input  logic [15:0] i_wdata1,
    input  logic        i_we_n0,
    input  logic        i_we_n1,
    input  logic        i_clr_status,
    output logic [1:0]  o_grant,
    output logic [19:0] o_SRAM_ADDR,
    output logic        o_SRAM_WE_N,
    output logic [15:0] o_dq_out,
    output logic        o_dq_oe,
    output logic        o_busy,
    output logic        o_timeout,
    output logic        o_overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SLOT0 = 2'd1;
    localparam logic [1:0] ST_GAP0  = 2'd2;
    localparam logic [1:0] ST_SLOT1 = 2'd3;

    localparam int unsigned         CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             in_slot;
    logic             cnt_at_last;

    assign in_slot     = (state_q == ST_SLOT0) || (state_q == ST_SLOT1);
    assign cnt_at_last = (cnt_q == CNT_LAST);

    // Next-state selection; a done in the same cycle as the timeout wins,
    // so the timeout pulse is only armed when the owner's done is absent.
    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_start) begin
                    if (i_req[0]) begin
                        state_d = ST_SLOT0;
                    end else if (i_req[1]) begin
                        state_d = ST_SLOT1;
                    end
                end
            end
            ST_SLOT0: begin
                if (i_done[0]) begin
                    state_d = ST_GAP0;
                end else if (cnt_at_last) begin
                    state_d   = ST_GAP0;
                    timeout_d = 1'b1;
                end
            end
            ST_GAP0: begin
                state_d = i_req[1] ? ST_SLOT1 : ST_IDLE;
            end
            ST_SLOT1: begin
                if (i_done[1]) begin
                    state_d = ST_IDLE;
                end else if (cnt_at_last) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot cycle counter: zero on any state change (covers slot entry),
    // counts while a slot is held. It never passes CNT_LAST because the
    // slot is forced to end there.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && in_slot) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Sticky overrun: a frame start outside IDLE sets it, and a set beats
    // a coincident clear.
    always_comb begin
        overrun_d = overrun_q;
        if (i_frame_start && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
        end else if (i_clr_status) begin
            overrun_d = 1'b0;
        end
    end

    // State, counter and status registers with asynchronous active-low reset.
    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    // SRAM bus mux. It decodes only the registered state, so an asynchronous
    // reset drops the DQ driver and write enable without waiting for an edge.
    always_comb begin
        o_grant     = 2'b00;
        o_SRAM_ADDR = '0;
        o_SRAM_WE_N = 1'b1;
        o_dq_oe     = 1'b0;
        o_dq_out    = '0;
        case (state_q)
            ST_SLOT0: begin
                o_grant     = 2'b01;
                o_SRAM_ADDR = i_addr0;
                o_SRAM_WE_N = i_we_n0;
                o_dq_oe     = ~i_we_n0;
                o_dq_out    = i_we_n0 ? 16'h0000 : i_wdata0;
            end
            ST_SLOT1: begin
                o_grant     = 2'b10;
                o_SRAM_ADDR = i_addr1;
                o_SRAM_WE_N = i_we_n1;
                o_dq_oe     = ~i_we_n1;
                o_dq_out    = i_we_n1 ? 16'h0000 : i_wdata1;
            end
            default: begin
                o_grant     = 2'b00;
                o_SRAM_ADDR = '0;
                o_SRAM_WE_N = 1'b1;
                o_dq_oe     = 1'b0;
                o_dq_out    = '0;
            end
        endcase
    end

    assign o_busy    = (state_q != ST_IDLE);
    assign o_timeout = timeout_q;
    assign o_overrun = overrun_q;

endmodule
